mux8_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one MUX8 datapath between 8 requesters.

---
 rtl/mux8_rr_arbiter_if.sv | 12 +
 rtl/mux8_rr_arbiter.sv | 80 ++++++++
 tb/tb_mux8_rr_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the MUX8 round-robin arbiter.
// The master side drives the request vector; the slave (arbiter) side returns the grant.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] select;
  logic [2:0] owner;
  logic       valid;
  logic       timeout;

  modport master (output req, input select, owner, valid, timeout);
  modport slave  (input req, output select, owner, valid, timeout);
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one MUX8 datapath among 8 requesters, with an optional
// per-tenure hold limit. All outputs are registered; select is always one-hot or zero.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  mux8_rr_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  // With no hold limit the counter is irrelevant, so just let it park at all-ones.
  localparam logic [CNT_W-1:0] CNT_SAT  = (MAX_HOLD == 0) ? '1 : HOLD_LIM;

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       win;
  logic             owner_req;
  logic             hold_expired;

  assign owner_req    = bus.req[bus.owner];
  assign hold_expired = (MAX_HOLD != 0) && (cnt == HOLD_LIM);

  // Walk from lowest priority (ptr itself) up to highest (ptr+1) so the last hit wins.
  // NOTE: win gets a default before the loop so the block never infers a latch.
  always_comb begin
    logic [2:0] idx;
    win = ptr;
    for (int i = 8; i >= 1; i--) begin
      idx = ptr + 3'(i);
      if (bus.req[idx]) win = idx;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd7;
      cnt         <= '0;
      bus.select  <= 8'h00;
      bus.owner   <= 3'd0;
      bus.valid   <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            bus.select <= 8'b1 << win;
            bus.owner  <= win;
            bus.valid  <= 1'b1;
            ptr        <= win;
            cnt        <= CNT_W'(1);
            state      <= GRANT;
          end
        end
        GRANT: begin
          // A drop coincident with expiry is a plain drop: timeout only when still requesting.
          if (!owner_req || hold_expired) begin
            bus.select  <= 8'h00;
            bus.owner   <= 3'd0;
            bus.valid   <= 1'b0;
            bus.timeout <= owner_req;
            state       <= IDLE;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a behavioural model predicts each cycle's outputs,
// a separate monitor compares them and checks one-hot, valid and starvation properties.
module tb_mux8_rr_arbiter;

  localparam int MAX_HOLD   = 16;
  localparam int WAIT_BOUND = 7 * (MAX_HOLD + 1) + 1;

  typedef struct packed {
    logic [7:0] select;
    logic [2:0] owner;
    logic       valid;
    logic       timeout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, for how many cycles, and where the rotation stands.
  bit   m_busy;
  int   m_ptr;
  int   m_owner;
  int   m_held;
  exp_t m_exp;

  function automatic void model_step(input logic [7:0] r, input logic rst_ok);
    m_exp = '0;
    if (!rst_ok) begin
      m_busy = 0; m_ptr = 7; m_owner = 0; m_held = 0;
      return;
    end
    if (!m_busy) begin
      for (int i = 1; i <= 8; i++) begin
        int c;
        c = (m_ptr + i) % 8;
        if (r[c]) begin
          m_busy = 1; m_owner = c; m_ptr = c; m_held = 1;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_busy = 0; m_owner = 0;
    end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
      m_busy = 0; m_owner = 0;
      m_exp.timeout = 1'b1;
    end else begin
      m_held++;
    end
    if (m_busy) begin
      m_exp.select = 8'(1 << m_owner);
      m_exp.owner  = 3'(m_owner);
      m_exp.valid  = 1'b1;
    end
  endfunction

  task automatic tick(input logic [7:0] nxt);
    @(posedge clk);
    model_step(bus.req, rst_n);
    sb_q.push_back(m_exp);
    #1 bus.req = nxt;
  endtask

  // Monitor: pop one expectation per cycle and check standing properties.
  int pend_age[8];
  initial begin
    exp_t e;
    int   worst;
    foreach (pend_age[k]) pend_age[k] = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("select",  bus.select  === e.select,  32'(bus.select),  32'(e.select));
        check("owner",   bus.owner   === e.owner,   32'(bus.owner),   32'(e.owner));
        check("valid",   bus.valid   === e.valid,   32'(bus.valid),   32'(e.valid));
        check("timeout", bus.timeout === e.timeout, 32'(bus.timeout), 32'(e.timeout));
      end
      check("onehot0", $onehot0(bus.select), 32'(bus.select), 32'h0);
      check("valid_vs_select", bus.valid === (|bus.select),
            32'(bus.valid), 32'(|bus.select));
      worst = 0;
      for (int k = 0; k < 8; k++) begin
        if (!rst_n || !bus.req[k] || (bus.valid && bus.owner == 3'(k))) pend_age[k] = 0;
        else pend_age[k]++;
        if (pend_age[k] > worst) worst = pend_age[k];
      end
      check("starvation", worst <= WAIT_BOUND, 32'(worst), 32'(WAIT_BOUND));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nxt;
    bit         dropped;
    rst_n   = 1'b0;
    bus.req = 8'h00;
    repeat (3) tick(8'h00);
    rst_n = 1'b1;

    // Reset mid-grant: owner 5, then async reset, then all request after release.
    repeat (5) tick(8'h20);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_select", bus.select === 8'h00, 32'(bus.select), 32'h0);
    check("async_reset_valid",  bus.valid  === 1'b0,  32'(bus.valid),  32'h0);
    tick(8'hFF);
    tick(8'hFF);
    rst_n = 1'b1;
    repeat (3) tick(8'hFF);
    repeat (3) tick(8'h00);

    // Single request and drop.
    repeat (4) tick(8'h04);
    repeat (3) tick(8'h00);

    // Round robin: everyone requests, each owner drops after 3 grant cycles.
    repeat (50) begin
      tick(8'hFF);
      if (m_busy && m_held == 3) bus.req = 8'hFF & ~(8'b1 << m_owner);
    end
    repeat (3) tick(8'h00);

    // Timeout with a lone requester, then 0 and 7 contending across a timeout.
    repeat (40) tick(8'h01);
    repeat (3) tick(8'h00);
    tick(8'h01);
    repeat (24) tick(8'h81);
    repeat (3) tick(8'h00);

    // Owner drops on exactly its last allowed cycle.
    dropped = 0;
    repeat (25) begin
      tick(8'h01);
      if (!dropped && m_busy && m_held == MAX_HOLD) begin
        bus.req = 8'h00;
        dropped = 1;
      end
    end
    repeat (3) tick(8'h00);

    // Random traffic obeying hold-until-served; owners drop at random.
    repeat (10000) begin
      nxt = bus.req | (8'($urandom) & 8'($urandom) & 8'($urandom));
      tick(nxt);
      if (m_busy && $urandom_range(0, 5) == 0) bus.req[m_owner] = 1'b0;
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size() == 0, 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
